// File: rtl/knn_memory_responder.sv
// KNN bus memory responder: word array with pipelined reads, bus writes and host load.
// Optional KNN_MEMRESP_STATS_EN adds rd_count/wr_count saturating counters.
module knn_memory_responder #(
  parameter int W         = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 32,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddress,
  output logic [W-1:0]      readdata,
  output logic              readdatavalid,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [W-1:0]      writedata,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [W-1:0]      load_data,
`ifdef KNN_MEMRESP_STATS_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
`endif
  output logic              addr_error
);

  localparam int SH = $clog2(ADDR_STEP);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(ADDR_STEP - 1);
  localparam logic [ADDR_W-1:0] LIM  = ADDR_W'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;
  logic [ADDR_W-1:0] ld_off;
  logic              rd_ok;
  logic              wr_ok;
  logic              ld_ok;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     ld_idx;
  logic [W-1:0]      rd_word;

  logic              we;
  logic [IW-1:0]     w_idx;
  logic [W-1:0]      w_data;

  logic              tail_v;
  logic [W-1:0]      tail_d;

  // Address decode: offset from base must be aligned and inside the array.
  always_comb begin
    rd_off = readaddress - BASE;
    wr_off = writeaddress - BASE;
    ld_off = load_addr - BASE;
    rd_ok = (readaddress >= BASE)
         && ((rd_off & MASK) == '0)
         && ((rd_off >> SH) < LIM);
    wr_ok = (writeaddress >= BASE)
         && ((wr_off & MASK) == '0)
         && ((wr_off >> SH) < LIM);
    ld_ok = (load_addr >= BASE)
         && ((ld_off & MASK) == '0)
         && ((ld_off >> SH) < LIM);
    rd_idx = IW'(rd_off >> SH);
    wr_idx = IW'(wr_off >> SH);
    ld_idx = IW'(ld_off >> SH);
    rd_word = rd_ok ? mem[rd_idx] : '0;
  end

  // Single write port: host load wins over a bus write in the same cycle.
  always_comb begin
    we = 1'b0;
    w_idx = wr_idx;
    w_data = writedata;
    if (load_en) begin
      we = ld_ok;
      w_idx = ld_idx;
      w_data = load_data;
    end else if (write) begin
      we = wr_ok;
    end
  end

  // Array storage; reads see the pre-edge value (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[w_idx] <= w_data;
    end
  end

  generate
    if (READ_LAT > 1) begin : g_pipe
      localparam int NS = READ_LAT - 1;
      logic [W-1:0] sd [NS];
      logic [NS-1:0] sv;

      // Intermediate read stages carrying data and a valid bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          sv <= '0;
          for (int i = 0; i < NS; i++) sd[i] <= '0;
        end else begin
          sv[0] <= read;
          sd[0] <= rd_word;
          for (int i = 1; i < NS; i++) begin
            sv[i] <= sv[i-1];
            sd[i] <= sd[i-1];
          end
        end
      end

      assign tail_v = sv[NS-1];
      assign tail_d = sd[NS-1];
    end else begin : g_direct
      assign tail_v = read;
      assign tail_d = rd_word;
    end
  endgenerate

  // Final stage: readdata holds until the next valid result; errors pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
      readdatavalid <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      readdatavalid <= tail_v;
      if (tail_v) readdata <= tail_d;
      addr_error <= (read && !rd_ok)
                 || (write && !wr_ok)
                 || (load_en && !ld_ok);
    end
  end

`ifdef KNN_MEMRESP_STATS_EN
  // Saturating counters of legal reads and executed bus writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (read && rd_ok && rd_count != 32'hFFFF_FFFF)
        rd_count <= rd_count + 32'd1;
      if (write && wr_ok && !load_en && wr_count != 32'hFFFF_FFFF)
        wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule
